// File: rtl/bus_arb_pkg.sv
// Shared definitions for the four-master round-robin bus arbiter.
//
// Contents:
//   N_MST        number of masters (fixed at 4)
//   ID_W         width of a master index
//   ST_IDLE/ST_GRANT  raw state encodings; arb_state_e is built on top of them
//   id_to_onehot converts a master index into a one-hot grant vector
package bus_arb_pkg;

    localparam int unsigned N_MST = 4;
    localparam int unsigned ID_W  = 2;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GRANT = 2'b01;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StGrant = ST_GRANT
    } arb_state_e;

    function automatic logic [N_MST-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [N_MST-1:0] one;
        one = {{(N_MST-1){1'b0}}, 1'b1};
        return one << id;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker for four requesters.
//
// Scans req starting at (ptr+1) mod 4 and wrapping, so ptr itself is checked last.
// Ports:
//   req   [3:0]  request vector
//   ptr   [1:0]  index of the most recent owner
//   found        at least one request bit is set
//   idx   [1:0]  index of the winning requester (0 when found=0)
module rr_pick4
    import bus_arb_pkg::*;
(
    input  logic [N_MST-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    always_comb begin
        logic [ID_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = ptr;
        for (int unsigned i = 1; i <= N_MST; i++) begin
            // 2-bit addition wraps naturally, giving the modulo-4 scan order
            cand = ptr + ID_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter4.sv
// Four-master round-robin arbiter for the shared system bus.
//
// grant is one-hot (or zero) and registered; grant_id drives the bus mux select and busy
// flags an active grant. All three outputs come from registers updated together.
// When BUS_ARB_TIMEOUT_EN is defined, an owner that has held the bus for MAX_HOLD cycles
// is forced to hand over if another master is waiting and the owner's lock bit is low.
// Without it, an owner keeps the bus while its req stays high and lock is ignored.
//
// Ports:
//   clk       bus clock, rising edge
//   reset     asynchronous active-high reset
//   req [3:0] level requests, one per master
//   lock[3:0] per-master lock; only the owner's bit matters (timeout build only)
//   grant[3:0] one-hot grant
//   grant_id [1:0] index of current owner, valid while busy
//   busy      any grant active
module bus_rr_arbiter4
    import bus_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_MST-1:0] req,
    input  logic [N_MST-1:0] lock,
    output logic [N_MST-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy
);

    arb_state_e       state_q, state_d;
    logic [N_MST-1:0] grant_q, grant_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             busy_q, busy_d;
    logic [ID_W-1:0]  last_q, last_d;

    logic             owner_req;
    logic             others_pending;
    logic             timeout_fire;
    logic [ID_W-1:0]  pick_ptr;
    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;

    assign owner_req      = req[id_q];
    assign others_pending = |(req & ~grant_q);

    // In IDLE rotate from the last owner; in GRANT rotate from the current owner.
    assign pick_ptr = (state_q == StGrant) ? id_q : last_q;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    assign timeout_fire = (state_q == StGrant) && (hold_q == HOLD_MAX) && others_pending &&
                          !lock[id_q];

    // Counts grant cycles of the current owner; cleared on every change of ownership.
    always_comb begin
        hold_d = '0;
        if (state_q == StGrant && owner_req && !timeout_fire) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_cfg;

    assign timeout_fire = 1'b0;
    assign unused_cfg   = (^lock) ^ (MAX_HOLD != 0);
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        busy_d  = busy_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StGrant;
                    id_d    = pick_idx;
                    grant_d = id_to_onehot(pick_idx);
                    busy_d  = 1'b1;
                end
            end
            StGrant: begin
                if (!owner_req || timeout_fire) begin
                    last_d = id_q;
                    // The owner's own bit is scanned last, so any other requester wins.
                    if (pick_found && pick_idx != id_q) begin
                        id_d    = pick_idx;
                        grant_d = id_to_onehot(pick_idx);
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                        id_d    = '0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                id_d    = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            last_q  <= ID_W'(N_MST - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = id_q;
    assign busy     = busy_q;

endmodule

// File: doc/bus_rr_arbiter4.md
Name: bus_rr_arbiter4

Overview:
- Four-master round-robin arbiter for the shared system bus.
- Grants at most one master at a time. Grants are one-hot and registered.
- Optional hold-timeout stops one master from starving the others.
- Sits between the master request lines and the bus address/data mux; grant_id drives the mux select.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles before forced rotation (timeout build only). Legal range 2..256.
- N_MST, 4, number of masters. Fixed at 4; exists for package consistency only.

Ports:
- clk  input  1  bus clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  bus request, one bit per master; level, held while the master wants the bus.
- lock  input  4  per-master lock; while the owner's bit is high, forced rotation is suppressed.
- grant  output  4  one-hot grant, registered.
- grant_id  output  2  binary index of the current owner; valid when busy=1.
- busy  output  1  high when any grant is active.

Behaviour:
- Reset (async, active-high): state=IDLE, grant=4'b0000, grant_id=2'd0, busy=0, last=2'd3, hold_cnt=0. The last=3 value gives master 0 first priority after reset.
- Asserting reset mid-grant drops grant immediately, with no wait for a clock edge.
- States: IDLE, GRANT. 2-bit encoding from the package.
- Pick function (combinational): scan req starting at index (ptr+1) mod 4, wrapping; the first set bit wins.
- IDLE:
  - req==0 → stay in IDLE.
  - Otherwise → GRANT, owner=pick(last). Latency: req sampled at edge k, grant visible after edge k+1 (1 cycle).
- GRANT, evaluated each edge:
  - req[owner]=0 and other req pending: hand over directly to pick(owner), with no idle cycle. Set last=owner, hold_cnt=0.
  - req[owner]=0 and no other req: go to IDLE, grant=0, last=owner.
  - req[owner]=1: keep the grant; hold_cnt increments, saturating at MAX_HOLD-1.
- Timeout (only when the feature is compiled in):
  - Trigger: hold_cnt==MAX_HOLD-1 and another req is pending and lock[owner]=0.
  - Action: forced handover to pick(owner) on that edge. The owner loses the grant even though req is still high; it re-enters rotation as a normal requester.
- grant is always one-hot or zero, never multi-hot.
- grant_id and busy are registered together with grant and are consistent in every cycle.
- Simultaneous requests: rotation order decides; there is no fixed priority except the reset pointer.
- A req pulse that arrives and leaves between edges is never sampled and is ignored.
- lock bits of non-owners are ignored.
- hold_cnt width: $clog2(MAX_HOLD).

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined: hold counter and forced rotation present, as described above.
- Undefined:
  - hold_cnt logic is removed.
  - An owner keeps the bus for as long as its req stays high.
  - lock has no effect but remains a port, so the interface is identical in both builds.

Decomposition:
- Package bus_arb_pkg contains:
  - state encoding constants ST_IDLE=2'b00, ST_GRANT=2'b01.
  - N_MST=4.
  - ID width constant 2.
- Sub-module rr_pick4: purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: found, idx[1:0].
  - Instantiated once; top-level holds the FSM, pointer, counter and output registers.

Test Plan:
- Reset state: hold reset=1 with req=4'b1111, then release → grant=0 during reset. First edge after release: grant=4'b0001, grant_id=0.
- Round-robin handover: req=4'b1111; each owner drops its req for exactly one edge, then re-raises → grant sequence 0001→0010→0100→1000→0001, with no zero-grant cycle between owners.
- Idle return: single req[2] pulse of 3 cycles from IDLE → grant=0100 one cycle after assert, grant=0 one cycle after deassert, busy follows grant, last=2.
- Timeout (BUS_ARB_TIMEOUT_EN, MAX_HOLD=8): req[0] held continuously, req[1] raised at cycle 2 of the grant → grant moves to 0010 after exactly 8 grant cycles of master 0. With lock[0]=1, master 0 keeps the grant indefinitely.
- No timeout (macro undefined): same stimulus as the timeout scenario → master 0 keeps the grant for 50 cycles; handover occurs one edge after req[0] falls.
- Reset mid-grant: assert reset asynchronously mid-cycle while grant=0100 → grant=0 before the next clock edge. After release with req=4'b0100, grant=0100 (pointer restarted at 3, scan 0,1,2).
